// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter_if
// Description : Bundle of the requester-side valid/ready/last bursts and the
//               FIFO write-side signals shared by the round-robin write
//               arbiter.
//               master - arbiter view (drives ready, FIFO write, status)
//               slave  - requester/FIFO view (drives valid, data, last, full)
// Signals     : req_valid/req_data/req_last/req_ready - per-requester bursts
//               fifo_full/fifo_wr_en/fifo_wr_data      - FIFO write port
//               grant_id/busy/timeout_err              - arbiter status
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 2
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic [ID_WIDTH-1:0]           grant_id;
   logic                          busy;
   logic                          timeout_err;

   modport master (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, timeout_err
   );

   modport slave (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, timeout_err
   );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing one FIFO write port among
//               NUM_REQ burst requesters. The port stays locked to one
//               requester from its first to its last beat, and a watchdog
//               aborts a locked burst whose requester idles for TIMEOUT
//               consecutive cycles (TIMEOUT = 0 disables it).
// Ports       : clk - FIFO write clock
//               rst - synchronous active-high reset
//               bus - fifo_wr_arbiter_if.master (requesters + FIFO write)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 2,
   parameter int TIMEOUT    = 15
) (
   input  wire logic         clk,
   input  wire logic         rst,
   fifo_wr_arbiter_if.master bus
);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int PAD_W = 2 ** ID_WIDTH;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_LOCK = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [ID_WIDTH-1:0]   grant_q, grant_d;
   logic [ID_WIDTH-1:0]   last_q,  last_d;
   logic [CNT_W-1:0]      stall_q, stall_d;
   logic                  tout_q,  tout_d;

   logic [PAD_W-1:0]      w_valid_pad;
   logic [PAD_W-1:0]      w_last_pad;
   logic                  w_gvalid;
   logic                  w_glast;
   logic                  w_xfer;
   logic                  w_found;
   logic [ID_WIDTH-1:0]   w_pick;
   logic [DATA_WIDTH-1:0] w_gdata;
   int                    w_cand;

   // Granted requester view and rotating-priority search. Vectors are padded
   // to 2**ID_WIDTH so they can be indexed directly by an ID.
   always_comb begin
      w_valid_pad                = '0;
      w_last_pad                 = '0;
      w_valid_pad[NUM_REQ-1:0]   = bus.req_valid;
      w_last_pad[NUM_REQ-1:0]    = bus.req_last;
      w_gvalid                   = w_valid_pad[grant_q];
      w_glast                    = w_last_pad[grant_q];
      w_xfer                     = (state_q == S_LOCK) && w_gvalid && !bus.fifo_full;

      w_gdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == ID_WIDTH'(i)) begin
            w_gdata = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      // Search starts just after the previous winner and wraps, so the
      // previous winner is examined last.
      w_found = 1'b0;
      w_pick  = '0;
      w_cand  = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = int'(last_q) + k;
         if (w_cand >= NUM_REQ) begin
            w_cand = w_cand - NUM_REQ;
         end
         if (!w_found && w_valid_pad[ID_WIDTH'(w_cand)]) begin
            w_found = 1'b1;
            w_pick  = ID_WIDTH'(w_cand);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= ID_WIDTH'(NUM_REQ - 1);
         stall_q <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         stall_q <= stall_d;
         tout_q  <= tout_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      stall_d = stall_q;
      tout_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_found) begin
               state_d = S_LOCK;
               grant_d = w_pick;
               last_d  = w_pick;
               stall_d = '0;
            end
         end
         S_LOCK: begin
            if (w_xfer) begin
               stall_d = '0;
               if (w_glast) begin
                  state_d = S_IDLE;
               end
            end else if (!w_gvalid) begin
               // Counter would reach TIMEOUT at this edge: abort instead.
               // Full-blocked cycles with valid high fall through untouched.
               if ((TIMEOUT != 0) && (stall_q == CNT_W'(TIMEOUT - 1))) begin
                  state_d = S_IDLE;
                  tout_d  = 1'b1;
                  stall_d = '0;
               end else if (stall_q != {CNT_W{1'b1}}) begin
                  stall_d = stall_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_ready[i] = (state_q == S_LOCK) && (grant_q == ID_WIDTH'(i)) && !bus.fifo_full;
      end
      bus.fifo_wr_en   = w_xfer;
      bus.fifo_wr_data = (state_q == S_LOCK) ? w_gdata : '0;
      bus.grant_id     = grant_q;
      bus.busy         = (state_q == S_LOCK);
      bus.timeout_err  = tout_q;
   end
endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter: directed scenario
//               tasks plus a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;
   localparam int TO = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.fifo_full = 1'b0;
   endtask

   task automatic drive(input int i, input bit v, input logic [DW-1:0] d, input bit l);
      bus.req_valid[i]           = v;
      bus.req_data[i*DW +: DW]   = d;
      bus.req_last[i]            = l;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = '1;
      bus.req_last  = '1;
      bus.req_data  = $urandom;
      bus.fifo_full = 1'b0;
      @(negedge clk); #1;
      n_cmp++; if (bus.req_ready !== 4'b0)   begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
      n_cmp++; if (bus.fifo_wr_en !== 1'b0)  begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", bus.fifo_wr_en); end
      n_cmp++; if (bus.fifo_wr_data !== 8'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.fifo_wr_data); end
      n_cmp++; if (bus.grant_id !== 2'd0)    begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", bus.grant_id); end
      n_cmp++; if (bus.busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_tout: got %b expected 0", bus.timeout_err); end
      rst = 1'b0;
      clear_inputs();
   endtask

   task automatic test_single_burst();
      logic [DW-1:0] beats [3];
      beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
      do_reset();
      @(negedge clk);
      drive(0, 1'b1, beats[0], 1'b0);
      #1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b wr_en=%b expected 0/0", bus.busy, bus.fifo_wr_en); end
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         drive(0, 1'b1, beats[b], (b == 2));
         #1;
         n_cmp++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant: got busy=%b grant=%0d expected 1/0", bus.busy, bus.grant_id); end
         n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== beats[b]) begin n_fail++; $display("FAIL single_beat%0d: got wr_en=%b data=%h expected 1/%h", b, bus.fifo_wr_en, bus.fifo_wr_data, beats[b]); end
         n_cmp++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready); end
      end
      @(negedge clk);
      drive(0, 1'b0, 8'h00, 1'b0);
      #1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_end: got busy=%b wr_en=%b expected 0/0", bus.busy, bus.fifo_wr_en); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int g = 0; g < 8; g++) begin
         @(negedge clk);
         if (g == 0) begin
            for (int i = 0; i < N; i++) drive(i, 1'b1, 8'(8'h10 + i), 1'b1);
         end
         #1;
         n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_bubble%0d: got busy=%b expected 0", g, bus.busy); end
         @(negedge clk); #1;
         n_cmp++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'(g % N)) begin n_fail++; $display("FAIL rr_grant%0d: got busy=%b grant=%0d expected 1/%0d", g, bus.busy, bus.grant_id, g % N); end
         n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'(8'h10 + g % N)) begin n_fail++; $display("FAIL rr_data%0d: got wr_en=%b data=%h expected 1/%h", g, bus.fifo_wr_en, bus.fifo_wr_data, 8'(8'h10 + g % N)); end
      end
      clear_inputs();
   endtask

   task automatic test_no_interleave();
      logic [DW-1:0] got [$];
      logic [DW-1:0] exp_q [5];
      exp_q[0] = 8'h20; exp_q[1] = 8'h21; exp_q[2] = 8'h22; exp_q[3] = 8'h23; exp_q[4] = 8'h30;
      do_reset();
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         case (s)
            0: drive(1, 1'b1, 8'h20, 1'b0);
            2: begin drive(1, 1'b1, 8'h21, 1'b0); drive(2, 1'b1, 8'h30, 1'b1); end
            3: drive(1, 1'b1, 8'h22, 1'b0);
            4: drive(1, 1'b1, 8'h23, 1'b1);
            5: drive(1, 1'b0, 8'h00, 1'b0);
            7: drive(2, 1'b0, 8'h00, 1'b0);
            default: ;
         endcase
         #1;
         if (bus.fifo_wr_en === 1'b1) got.push_back(bus.fifo_wr_data);
         if (s >= 2 && s <= 5) begin
            n_cmp++; if (bus.req_ready[2] !== 1'b0) begin n_fail++; $display("FAIL ni_ready2_s%0d: got %b expected 0", s, bus.req_ready[2]); end
         end
         if (s == 6) begin
            n_cmp++; if (bus.grant_id !== 2'd2 || bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL ni_grant2: got grant=%0d ready=%b expected 2/0100", bus.grant_id, bus.req_ready); end
         end
      end
      n_cmp++; if (got.size() != 5) begin n_fail++; $display("FAIL ni_count: got %0d writes expected 5", got.size()); end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL ni_fifo%0d: got %h expected %h", i, got[i], exp_q[i]); end
      end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      drive(0, 1'b1, 8'h40, 1'b0);
      @(negedge clk); #1;
      n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'h40) begin n_fail++; $display("FAIL bp_beat0: got wr_en=%b data=%h expected 1/40", bus.fifo_wr_en, bus.fifo_wr_data); end
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         if (j == 0) begin drive(0, 1'b1, 8'h41, 1'b0); bus.fifo_full = 1'b1; end
         #1;
         n_cmp++; if (bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL bp_stall%0d: got wr_en=%b ready=%b expected 0/0000", j, bus.fifo_wr_en, bus.req_ready); end
         n_cmp++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d: got tout=%b busy=%b expected 0/1", j, bus.timeout_err, bus.busy); end
      end
      @(negedge clk);
      bus.fifo_full = 1'b0;
      #1;
      n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'h41) begin n_fail++; $display("FAIL bp_resume: got wr_en=%b data=%h expected 1/41", bus.fifo_wr_en, bus.fifo_wr_data); end
      @(negedge clk);
      drive(0, 1'b1, 8'h42, 1'b1);
      #1;
      n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'h42) begin n_fail++; $display("FAIL bp_last: got wr_en=%b data=%h expected 1/42", bus.fifo_wr_en, bus.fifo_wr_data); end
      @(negedge clk);
      drive(0, 1'b0, 8'h00, 1'b0);
      #1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL bp_end: got busy=%b tout=%b expected 0/0", bus.busy, bus.timeout_err); end
   endtask

   task automatic test_watchdog();
      int pulses = 0;
      do_reset();
      for (int s = 0; s < 9; s++) begin
         @(negedge clk);
         case (s)
            0: drive(0, 1'b1, 8'h50, 1'b0);
            2: drive(0, 1'b1, 8'h51, 1'b0);
            3: begin drive(0, 1'b0, 8'h00, 1'b0); drive(1, 1'b1, 8'h60, 1'b1); end
            8: drive(1, 1'b0, 8'h00, 1'b0);
            default: ;
         endcase
         #1;
         if (bus.timeout_err === 1'b1) pulses++;
         if (s >= 3 && s <= 5) begin
            n_cmp++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0 || bus.req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL wd_wait%0d: got busy=%b tout=%b rdy1=%b expected 1/0/0", s, bus.busy, bus.timeout_err, bus.req_ready[1]); end
         end
         if (s == 6) begin
            n_cmp++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL wd_abort: got busy=%b tout=%b expected 0/1", bus.busy, bus.timeout_err); end
         end
         if (s == 7) begin
            n_cmp++; if (bus.grant_id !== 2'd1 || bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'h60) begin n_fail++; $display("FAIL wd_next: got grant=%0d wr_en=%b data=%h expected 1/1/60", bus.grant_id, bus.fifo_wr_en, bus.fifo_wr_data); end
         end
      end
      n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL wd_pulses: got %0d expected 1", pulses); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      @(negedge clk);
      drive(0, 1'b1, 8'h70, 1'b0);
      @(negedge clk); #1;
      n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'h70) begin n_fail++; $display("FAIL rmb_beat0: got wr_en=%b data=%h expected 1/70", bus.fifo_wr_en, bus.fifo_wr_data); end
      @(negedge clk);
      drive(0, 1'b1, 8'h71, 1'b0);
      rst = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL rmb_ctrl: got busy=%b wr_en=%b ready=%b expected 0/0/0000", bus.busy, bus.fifo_wr_en, bus.req_ready); end
      n_cmp++; if (bus.fifo_wr_data !== 8'h0 || bus.grant_id !== 2'd0 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rmb_vals: got data=%h grant=%0d tout=%b expected 00/0/0", bus.fifo_wr_data, bus.grant_id, bus.timeout_err); end
      rst = 1'b0;
      drive(0, 1'b1, 8'h77, 1'b1);
      drive(1, 1'b1, 8'h88, 1'b1);
      drive(3, 1'b1, 8'h99, 1'b1);
      @(negedge clk); #1;
      n_cmp++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0 || bus.fifo_wr_data !== 8'h77) begin n_fail++; $display("FAIL rmb_first: got busy=%b grant=%0d data=%h expected 1/0/77", bus.busy, bus.grant_id, bus.fifo_wr_data); end
      clear_inputs();
   endtask

   task automatic test_random();
      int owner, lastw, gid, stall;
      bit tout, full, e_wr;
      logic [N-1:0] v, l, e_ready;
      logic [N*DW-1:0] d;
      logic [DW-1:0] e_data;
      do_reset();
      owner = -1; lastw = N - 1; gid = 0; stall = 0; tout = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            v[i] = ($urandom_range(0, 9) < 7);
            l[i] = ($urandom_range(0, 3) == 0);
            d[i*DW +: DW] = 8'($urandom);
         end
         full = ($urandom_range(0, 4) == 0);
         bus.req_valid = v;
         bus.req_last  = l;
         bus.req_data  = d;
         bus.fifo_full = full;
         #1;
         e_ready = '0; e_wr = 1'b0; e_data = '0;
         if (owner >= 0) begin
            e_ready[owner] = !full;
            e_wr           = v[owner] && !full;
            e_data         = d[owner*DW +: DW];
         end
         n_cmp++; if (bus.busy !== (owner >= 0)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, bus.busy, (owner >= 0)); end
         n_cmp++; if (bus.grant_id !== IW'(gid)) begin n_fail++; $display("FAIL rnd_grant c%0d: got %0d expected %0d", c, bus.grant_id, gid); end
         n_cmp++; if (bus.req_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, bus.req_ready, e_ready); end
         n_cmp++; if (bus.fifo_wr_en !== e_wr) begin n_fail++; $display("FAIL rnd_wr_en c%0d: got %b expected %b", c, bus.fifo_wr_en, e_wr); end
         n_cmp++; if (bus.fifo_wr_data !== e_data) begin n_fail++; $display("FAIL rnd_data c%0d: got %h expected %h", c, bus.fifo_wr_data, e_data); end
         n_cmp++; if (bus.timeout_err !== tout) begin n_fail++; $display("FAIL rnd_tout c%0d: got %b expected %b", c, bus.timeout_err, tout); end
         // Advance the model by one clock edge.
         tout = 1'b0;
         if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
               int cnd;
               cnd = (lastw + k) % N;
               if (v[cnd]) begin
                  owner = cnd; lastw = cnd; gid = cnd; stall = 0;
                  break;
               end
            end
         end else if (e_wr) begin
            stall = 0;
            if (l[owner]) owner = -1;
         end else if (!v[owner]) begin
            stall++;
            if (stall == TO) begin
               tout  = 1'b1;
               owner = -1;
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_burst();
      test_round_robin();
      test_no_interleave();
      test_backpressure();
      test_watchdog();
      test_reset_mid_burst();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no completion expected completion");
      $fatal(1, "bench timed out");
   end
endmodule
`default_nettype wire
